// File: rtl/plugboard_pairs.sv
// Enigma plugboard: a symbol-pair involution table with a two-symbol pair load,
// a multi-cycle clear back to identity, and combinational forward/backward lookups.
module plugboard_pairs #(
  parameter int SYM_W   = 6,
  parameter int SHIFT_W = 2
) (
  input  logic               clk,
  input  logic               srst_n,
  input  logic               load,
  input  logic [SYM_W-1:0]   code_in,
  input  logic               clear,
  input  logic               encrypt,
  input  logic               crypt_mode,
  input  logic [SYM_W-1:0]   fwd_in,
  input  logic [SYM_W-1:0]   bwd_in,
  output logic [SYM_W-1:0]   fwd_out,
  output logic [SYM_W-1:0]   bwd_out,
  output logic [SHIFT_W-1:0] shift_mode,
  output logic               busy,
  output logic               half,
  output logic               err,
  output logic [SYM_W-1:0]   pair_cnt
);

  localparam int N_SYM = 2**SYM_W;

  typedef enum logic [1:0] {IDLE, HALF, CLEAR} state_t;

  state_t           state, state_next;
  logic [SYM_W-1:0] tbl [N_SYM];
  logic [SYM_W-1:0] first;
  logic [SYM_W-1:0] clr_idx;
  logic [SYM_W-1:0] map_a, map_b;
  logic             pair_write, pair_reject;

  assign map_a = tbl[first];
  assign map_b = tbl[code_in];

  // A pair may only be written when both symbols are still unplugged; re-loading
  // an existing pair or a self-pair is accepted silently.
  always_comb begin
    state_next  = state;
    pair_write  = 1'b0;
    pair_reject = 1'b0;
    case (state)
      IDLE: begin
        if (clear)     state_next = CLEAR;
        else if (load) state_next = HALF;
      end
      HALF: begin
        if (clear) begin
          state_next = CLEAR;
        end else if (load) begin
          state_next  = IDLE;
          pair_write  = (first != code_in) && (map_a == first) && (map_b == code_in);
          pair_reject = (first != code_in) && !pair_write && (map_a != code_in);
        end
      end
      CLEAR: begin
        if (clr_idx == SYM_W'(N_SYM - 1)) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!srst_n) state <= IDLE;
    else         state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (!srst_n) begin
      for (int i = 0; i < N_SYM; i++) tbl[i] <= SYM_W'(i);
      first    <= '0;
      clr_idx  <= '0;
      pair_cnt <= '0;
      err      <= 1'b0;
    end else begin
      err <= pair_reject;
      case (state)
        IDLE, HALF: begin
          if (clear) begin
            clr_idx  <= '0;
            pair_cnt <= '0;
            first    <= '0;
          end else if (load && state == IDLE) begin
            first <= code_in;
          end else if (pair_write) begin
            tbl[first]   <= code_in;
            tbl[code_in] <= first;
            pair_cnt     <= pair_cnt + SYM_W'(1);
          end
        end
        CLEAR: begin
          tbl[clr_idx] <= clr_idx;
          clr_idx      <= clr_idx + SYM_W'(1);
        end
        default: ;
      endcase
    end
  end

  // The table is half-rewritten during CLEAR, so lookups bypass it with identity.
  assign busy       = (state == CLEAR);
  assign half       = (state == HALF);
  assign bwd_out    = busy ? bwd_in : tbl[bwd_in];
  assign fwd_out    = !encrypt ? '0 : (busy ? fwd_in : tbl[fwd_in]);
  assign shift_mode = crypt_mode ? bwd_out[SHIFT_W-1:0] : fwd_in[SHIFT_W-1:0];

endmodule

// File: tb/tb_plugboard_pairs.sv
// Self-checking bench for plugboard_pairs: directed scenarios followed by random
// load/clear/reset traffic, all compared against a pair-list reference model.
module tb_plugboard_pairs;

  localparam int SYM_W   = 6;
  localparam int SHIFT_W = 2;
  localparam int N_SYM   = 64;

  logic               clk = 1'b0;
  logic               srst_n, load, clear, encrypt, crypt_mode;
  logic [SYM_W-1:0]   code_in, fwd_in, bwd_in;
  logic [SYM_W-1:0]   fwd_out, bwd_out, pair_cnt;
  logic [SHIFT_W-1:0] shift_mode;
  logic               busy, half, err;

  plugboard_pairs #(.SYM_W(SYM_W), .SHIFT_W(SHIFT_W)) dut (
    .clk(clk), .srst_n(srst_n), .load(load), .code_in(code_in), .clear(clear),
    .encrypt(encrypt), .crypt_mode(crypt_mode), .fwd_in(fwd_in), .bwd_in(bwd_in),
    .fwd_out(fwd_out), .bwd_out(bwd_out), .shift_mode(shift_mode),
    .busy(busy), .half(half), .err(err), .pair_cnt(pair_cnt)
  );

  always #5 clk = ~clk;

  int model [N_SYM];
  bit m_half;
  int m_first;
  int m_busy_left;
  bit m_err;
  int checks;
  int passes;

  // Pair count derived from the table itself: every plugged pair moves two symbols.
  function automatic int model_pairs();
    int n = 0;
    for (int i = 0; i < N_SYM; i++) if (model[i] != i) n++;
    return n / 2;
  endfunction

  task automatic model_identity();
    for (int i = 0; i < N_SYM; i++) model[i] = i;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic applyStimulus(input bit ld, input int code, input bit clr, input bit rst_n);
    int a, b;
    load    = ld;
    code_in = SYM_W'(code);
    clear   = clr;
    srst_n  = rst_n;
    m_err   = 1'b0;
    if (!rst_n) begin
      model_identity();
      m_half = 1'b0; m_first = 0; m_busy_left = 0;
    end else if (m_busy_left > 0) begin
      m_busy_left--;
    end else if (clr) begin
      model_identity();
      m_half = 1'b0; m_first = 0; m_busy_left = N_SYM;
    end else if (ld) begin
      if (!m_half) begin
        m_first = code;
        m_half  = 1'b1;
      end else begin
        m_half = 1'b0;
        a = m_first;
        b = code;
        if (a == b) ;
        else if (model[a] == a && model[b] == b) begin
          model[a] = b;
          model[b] = a;
        end else if (model[a] == b) ;
        else m_err = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    load = 1'b0; clear = 1'b0; srst_n = 1'b1; code_in = '0;
  endtask

  task automatic lookup(input int f, input int b, input bit enc, input bit cm);
    fwd_in = SYM_W'(f); bwd_in = SYM_W'(b); encrypt = enc; crypt_mode = cm;
    #1;
  endtask

  task automatic checkOutput(input string tag);
    int f, b, exp_shift;
    bit enc, cm;
    f   = $urandom_range(0, N_SYM - 1);
    b   = $urandom_range(0, N_SYM - 1);
    enc = 1'($urandom_range(0, 1));
    cm  = 1'($urandom_range(0, 1));
    lookup(f, b, enc, cm);
    exp_shift = cm ? (model[b] % 4) : (f % 4);
    chk({tag, ".half"},       half,       m_half);
    chk({tag, ".busy"},       busy,       m_busy_left > 0);
    chk({tag, ".err"},        err,        m_err);
    chk({tag, ".pair_cnt"},   pair_cnt,   model_pairs());
    chk({tag, ".fwd_out"},    fwd_out,    enc ? model[f] : 0);
    chk({tag, ".bwd_out"},    bwd_out,    model[b]);
    chk({tag, ".shift_mode"}, shift_mode, exp_shift);
  endtask

  initial begin
    checks = 0; passes = 0;
    load = 0; clear = 0; code_in = '0; srst_n = 1'b0;
    encrypt = 0; crypt_mode = 0; fwd_in = '0; bwd_in = '0;
    model_identity();
    m_half = 0; m_first = 0; m_busy_left = 0; m_err = 0;

    applyStimulus(0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0);
    checkOutput("reset");

    // Basic pair 5<->9
    applyStimulus(1, 5, 0, 1);
    chk("basic.half_set", half, 1);
    checkOutput("basic_a");
    applyStimulus(1, 9, 0, 1);
    checkOutput("basic_b");
    lookup(5, 9, 1, 0);
    chk("basic.fwd5", fwd_out, 9);
    chk("basic.bwd9", bwd_out, 5);
    chk("basic.cnt", pair_cnt, 1);
    chk("basic.err", err, 0);
    chk("basic.half_clr", half, 0);

    // Gating and shift mode
    lookup(5, 5, 0, 1);
    chk("gate.fwd_off", fwd_out, 0);
    chk("shift.bwd", shift_mode, 1);
    lookup(6, 0, 1, 0);
    chk("shift.fwd", shift_mode, 2);

    // Conflict 5,20 then re-load of existing pair 9,5
    applyStimulus(1, 5, 0, 1);
    applyStimulus(1, 20, 0, 1);
    chk("conf.err", err, 1);
    checkOutput("conf");
    lookup(5, 20, 1, 0);
    chk("conf.fwd5", fwd_out, 9);
    chk("conf.bwd20", bwd_out, 20);
    applyStimulus(0, 0, 0, 1);
    chk("conf.err_once", err, 0);
    applyStimulus(1, 9, 0, 1);
    applyStimulus(1, 5, 0, 1);
    chk("repair.err", err, 0);
    chk("repair.cnt", pair_cnt, 1);

    // Self-pair
    applyStimulus(1, 7, 0, 1);
    applyStimulus(1, 7, 0, 1);
    lookup(7, 7, 1, 0);
    chk("self.fwd7", fwd_out, 7);
    chk("self.err", err, 0);
    chk("self.cnt", pair_cnt, 1);

    // Three pairs, then clear with a simultaneous load
    applyStimulus(1, 1, 0, 1);
    applyStimulus(1, 2, 0, 1);
    applyStimulus(1, 3, 0, 1);
    applyStimulus(1, 4, 0, 1);
    chk("clr.pre_cnt", pair_cnt, 3);
    applyStimulus(1, 33, 1, 1);
    checkOutput("clr_start");
    for (int i = 1; i <= N_SYM; i++) begin
      applyStimulus(1'(i % 3 == 0), $urandom_range(0, N_SYM - 1), 1'(i % 7 == 0), 1);
      checkOutput("clr_run");
    end
    chk("clr.busy_done", busy, 0);
    chk("clr.half", half, 0);
    chk("clr.cnt", pair_cnt, 0);

    // Reset mid-HALF with a pair already plugged
    applyStimulus(1, 2, 0, 1);
    applyStimulus(1, 3, 0, 1);
    applyStimulus(1, 11, 0, 1);
    applyStimulus(0, 0, 0, 0);
    lookup(2, 3, 1, 0);
    chk("rst_half.half", half, 0);
    chk("rst_half.fwd2", fwd_out, 2);
    chk("rst_half.bwd3", bwd_out, 3);

    // Reset mid-CLEAR
    applyStimulus(0, 0, 1, 1);
    for (int i = 0; i < 10; i++) applyStimulus(0, 0, 0, 1);
    chk("rst_clr.busy_pre", busy, 1);
    applyStimulus(0, 0, 0, 0);
    chk("rst_clr.busy", busy, 0);
    checkOutput("rst_clr");

    // Random traffic biased toward a small symbol range so conflicts are common
    for (int n = 0; n < 400; n++) begin
      int r;
      r = $urandom_range(0, 99);
      applyStimulus(1'($urandom_range(0, 2) != 0),
                    (r < 60) ? $urandom_range(0, 15) : $urandom_range(0, N_SYM - 1),
                    1'(r < 2), 1'(r != 99));
      checkOutput("rand");
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/plugboard_pairs.md
# plugboard_pairs

Parametrised plugboard for the Enigma datapath. It holds a symbol-to-symbol involution table of `2**SYM_W` entries, loaded one pair at a time through a two-symbol load sequence that rejects conflicting pairs. A multi-cycle clear sequence restores the identity mapping. It provides combinational forward and backward lookups, plus the rotor-B shift-mode select, between rotor B and the reflector.

## Interface
Parameters:
- `SYM_W`, default 6: symbol width; table depth `N_SYM = 2**SYM_W`.
- `SHIFT_W`, default 2: width of the shift-mode output; must satisfy `SHIFT_W <= SYM_W`.

Ports:
- `clk`, input, 1: clock.
- `srst_n`, input, 1: reset; synchronous, active-low.
- `load`, input, 1: load strobe; `code_in` is a pair symbol this cycle.
- `code_in`, input, SYM_W: symbol being loaded.
- `clear`, input, 1: start the clear-to-identity sequence.
- `encrypt`, input, 1: enables the forward lookup.
- `crypt_mode`, input, 1: shift-mode source select.
- `fwd_in`, input, SYM_W: forward lookup index, from rotor B.
- `bwd_in`, input, SYM_W: backward lookup index, from the reflector.
- `fwd_out`, output, SYM_W: `table[fwd_in]` when `encrypt`=1, else 0.
- `bwd_out`, output, SYM_W: `table[bwd_in]`.
- `shift_mode`, output, SHIFT_W: `crypt_mode` ? `bwd_out[SHIFT_W-1:0]` : `fwd_in[SHIFT_W-1:0]`.
- `busy`, output, 1: high while CLEAR runs.
- `half`, output, 1: high when the first symbol of a pair is pending.
- `err`, output, 1: one-cycle pulse when a pair is rejected.
- `pair_cnt`, output, SYM_W: number of distinct pairs currently plugged.

## Operation
- FSM states: IDLE, HALF, CLEAR. `half` = (state==HALF). `busy` = (state==CLEAR).
- **IDLE + `load`:** capture `code_in` into `first`, go to HALF.
- **HALF + `load`:** let `a`=`first`, `b`=`code_in`, then return to IDLE.
  - `a==b`: accepted no-op; table and `pair_cnt` unchanged.
  - `table[a]==a` and `table[b]==b`: write `table[a]=b`, `table[b]=a`, `pair_cnt+1`.
  - `table[a]==b` (already paired together): accepted no-op.
  - Otherwise (either symbol is plugged elsewhere): reject; `err`=1 for one cycle, table unchanged.
- **`clear` in IDLE or HALF:** go to CLEAR, reset the counter `clr_idx` to 0, set `pair_cnt` to 0, drop any pending `first`. `clear` has priority over a simultaneous `load`.
- **CLEAR:** each cycle write `table[clr_idx]=clr_idx` and increment `clr_idx`. After writing index `N_SYM-1`, return to IDLE.
  - `load` and `clear` are ignored in CLEAR.
  - During CLEAR, lookups return identity: `fwd_out` = `encrypt` ? `fwd_in` : 0, and `bwd_out` = `bwd_in`.
- The table remains an involution at all times outside CLEAR.
- `pair_cnt` saturates naturally at `N_SYM/2`; it never overflows given the conflict rule.

## Timing
- **Reset values (all outputs and state):** table = identity, state IDLE, `busy`=0, `half`=0, `err`=0, `pair_cnt`=0, `first`=0, `clr_idx`=0. `fwd_out`, `bwd_out` and `shift_mode` follow their combinational definitions on the identity table.
- **Lookups** are combinational from the registered table: zero latency.
- **Pair update:** a pair loaded on edge k (second symbol) is visible on lookups and in `pair_cnt` after edge k. `err` is high for the cycle following edge k only.
- **Clear:** `clear` sampled on edge k gives `busy`=1 from after edge k until after edge k+N_SYM (N_SYM cycles). Full identity is visible after edge k+N_SYM.
- **Reset mid-sequence:** `srst_n`=0 on any edge in HALF or CLEAR forces the reset values at that edge; no partial pair survives.
- Back-to-back loads are allowed: one symbol per cycle, so a pair completes every 2 cycles.

## Test plan
- **Basic pair:** reset, then load 5, load 9 → `fwd_out(5)`=9, `bwd_out(9)`=5, `pair_cnt`=1, `err`=0; `half` is 1 for exactly one cycle.
- **Conflict:** after 5↔9, load 5, load 20 → `err` pulses once, `table[5]`=9, `table[20]`=20, `pair_cnt`=1. Then load 9, load 5 → no error, `pair_cnt`=1.
- **Self-pair:** load 7, load 7 → `table[7]`=7, `pair_cnt` unchanged, `err`=0.
- **Clear:** plug 3 pairs, then `clear` together with `load` → `busy` high for 64 cycles, lookups return identity, the load is ignored, and `pair_cnt`=0 afterwards.
- **Reset mid-HALF and mid-CLEAR:** `srst_n`=0 → `half`=0, `busy`=0, identity table on the next cycle.
- **Gating / shift mode:** `encrypt`=0 → `fwd_out`=0. With 5↔9 plugged, `crypt_mode`=1 and `bwd_in`=5 → `shift_mode`=1 (9[1:0]). With `crypt_mode`=0 and `fwd_in`=6 → `shift_mode`=2.
